// File: rtl/bpsk_ber_checker_if.sv
// bpsk_ber_checker_if: stimulus and result bundle for the four-lane BPSK BER checker.
// master drives start/delay/window_len/valid/tx1..tx4/rx1..rx4 and observes
// busy/done/bit_errors/bit_count/sat/lane_err1..lane_err4; slave is the checker side.
interface bpsk_ber_checker_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 20
);
    logic             start;
    logic [4:0]       delay;
    logic [15:0]      window_len;
    logic             valid;
    logic [WIDTH-1:0] tx1, tx2, tx3, tx4;
    logic [WIDTH-1:0] rx1, rx2, rx3, rx4;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] bit_errors;
    logic [CNT_W-1:0] bit_count;
    logic             sat;
    logic [15:0]      lane_err1, lane_err2, lane_err3, lane_err4;
    modport master (
        output start, delay, window_len, valid, tx1, tx2, tx3, tx4, rx1, rx2, rx3, rx4,
        input  busy, done, bit_errors, bit_count, sat, lane_err1, lane_err2, lane_err3, lane_err4
    );
    modport slave (
        input  start, delay, window_len, valid, tx1, tx2, tx3, tx4, rx1, rx2, rx3, rx4,
        output busy, done, bit_errors, bit_count, sat, lane_err1, lane_err2, lane_err3, lane_err4
    );
endinterface

// File: rtl/bpsk_ber_checker.sv
// bpsk_ber_checker: windowed bit-error-rate checker comparing delayed tx decisions against rx decisions.
// Ports: clk, reset (sync, active-high); bus (slave modport of bpsk_ber_checker_if) carries
// start/delay/window_len/valid/tx1..4/rx1..4 in and busy/done/bit_errors/bit_count/sat/lane_err1..4 out.
// Optional: define BER_LANE_ERR_EN to build the per-lane 16-bit saturating error counters;
// otherwise lane_err1..4 are tied to zero.
module bpsk_ber_checker #(
    parameter int WIDTH     = 16,
    parameter int DELAY_MAX = 16,
    parameter int CNT_W     = 20
) (
    input  logic                clk,
    input  logic                reset,
    bpsk_ber_checker_if.slave   bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ALIGN = 2'd1;
    localparam logic [1:0] S_MEAS  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam int AW   = (DELAY_MAX > 1) ? $clog2(DELAY_MAX) : 1;
    localparam int DMAX = DELAY_MAX - 1;

    logic [1:0]       r_state;
    logic [3:0]       r_dl [DELAY_MAX];
    logic [AW-1:0]    r_dly;
    logic [15:0]      r_win;
    logic [15:0]      r_fill;
    logic [CNT_W-1:0] r_err;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;
    logic             r_done;

    logic [3:0]       w_tx, w_rx, w_ref, w_err;
    logic [2:0]       w_pop;
    logic [CNT_W:0]   w_cnt_sum, w_err_sum;
    logic [CNT_W-1:0] w_cnt_nx, w_err_nx;
    logic [15:0]      w_fill_nx;
    logic [AW-1:0]    w_dly;
    logic             w_start, w_count, w_align_end;

    // Hard decision is the sample MSB: 1 means -1, 0 means +1.
    assign w_tx = {bus.tx4[WIDTH-1], bus.tx3[WIDTH-1], bus.tx2[WIDTH-1], bus.tx1[WIDTH-1]};
    assign w_rx = {bus.rx4[WIDTH-1], bus.rx3[WIDTH-1], bus.rx2[WIDTH-1], bus.rx1[WIDTH-1]};
    // r_dl[0] already holds the previous valid sample, so delay d taps r_dl[d-1].
    assign w_ref = (r_dly == '0) ? w_tx : r_dl[r_dly - AW'(1)];
    assign w_err = w_ref ^ w_rx;
    assign w_pop = 3'(w_err[0]) + 3'(w_err[1]) + 3'(w_err[2]) + 3'(w_err[3]);
    assign w_cnt_sum = {1'b0, r_cnt} + (CNT_W+1)'(4);
    assign w_err_sum = {1'b0, r_err} + (CNT_W+1)'(w_pop);
    assign w_cnt_nx = w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
    assign w_err_nx = w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];
    assign w_fill_nx = r_fill + 16'd1;
    assign w_dly = (int'(bus.delay) > DMAX) ? AW'(DMAX) : AW'(bus.delay);
    assign w_start = bus.start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_count = (r_state == S_MEAS) && bus.valid;
    assign w_align_end = (r_dly == '0) || (bus.valid && w_fill_nx == 16'(r_dly));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DELAY_MAX; i++) r_dl[i] <= '0;
        end else if (bus.valid) begin
            r_dl[0] <= w_tx;
            for (int i = 1; i < DELAY_MAX; i++) r_dl[i] <= r_dl[i-1];
        end
    end

    always_ff @(posedge clk) begin
        r_done <= 1'b0;
        if (reset) begin
            r_state <= S_IDLE;
            r_dly   <= '0;
            r_win   <= '0;
            r_fill  <= '0;
            r_err   <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
        end else if (w_start) begin
            r_state <= S_ALIGN;
            r_dly   <= w_dly;
            r_win   <= bus.window_len;
            r_fill  <= '0;
            r_err   <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
        end else if (r_state == S_ALIGN) begin
            if (w_align_end) begin
                r_state <= (r_win == '0) ? S_DONE : S_MEAS;
                r_done  <= (r_win == '0);
                r_fill  <= '0;
            end else if (bus.valid) begin
                r_fill <= w_fill_nx;
            end
        end else if (w_count) begin
            r_cnt  <= w_cnt_nx;
            r_err  <= w_err_nx;
            r_sat  <= r_sat | (w_cnt_nx == '1) | (w_err_nx == '1);
            r_fill <= w_fill_nx;
            if (w_fill_nx == r_win) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
            end
        end
    end

    assign bus.busy       = (r_state == S_ALIGN) || (r_state == S_MEAS);
    assign bus.done       = r_done;
    assign bus.bit_errors = r_err;
    assign bus.bit_count  = r_cnt;
    assign bus.sat        = r_sat;

`ifdef BER_LANE_ERR_EN
    logic [15:0] r_lane [4];

    always_ff @(posedge clk) begin
        if (reset || w_start) begin
            for (int i = 0; i < 4; i++) r_lane[i] <= '0;
        end else if (w_count) begin
            for (int i = 0; i < 4; i++)
                if (w_err[i] && r_lane[i] != 16'hFFFF) r_lane[i] <= r_lane[i] + 16'd1;
        end
    end

    assign bus.lane_err1 = r_lane[0];
    assign bus.lane_err2 = r_lane[1];
    assign bus.lane_err3 = r_lane[2];
    assign bus.lane_err4 = r_lane[3];
`else
    assign bus.lane_err1 = '0;
    assign bus.lane_err2 = '0;
    assign bus.lane_err3 = '0;
    assign bus.lane_err4 = '0;
`endif
endmodule
